// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
// booth_mul_seq : sequential radix-2 Booth multiplier driving an external add/sub stage
// Rev 1.0
// ============================================================================
module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_x,
  output logic [WIDTH-1:0]     add_y,
  output logic                 add_sub,
  input  logic [WIDTH:0]       add_z
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  q_reg;
  logic [WIDTH-1:0]  m_reg;
  logic              q_m1;
  logic [CW-1:0]     count;
  logic              last_step;

  assign last_step = (state == RUN) && (count == CW'(WIDTH - 1));
  assign busy      = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    add_x      = '0;
    add_y      = '0;
    add_sub    = 1'b0;
    case (state)
      IDLE, DONE: state_next = start ? RUN : IDLE;
      RUN: begin
        add_x = acc;
        // Booth pair {Q[0],Q_-1}: 01 adds M, 10 subtracts M, 00/11 pass A through
        case ({q_reg[0], q_m1})
          2'b01: add_y = m_reg;
          2'b10: begin
            add_y   = m_reg;
            add_sub = 1'b1;
          end
          default: add_y = '0;
        endcase
        if (last_step) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      m_reg   <= '0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            acc   <= '0;
            q_reg <= multiplier;
            q_m1  <= 1'b0;
            m_reg <= multiplicand;
            count <= '0;
          end
        end
        RUN: begin
          // arithmetic right shift of {add_z, Q} keeps the 9th bit so M = -2^(W-1) stays exact
          acc   <= add_z[WIDTH:1];
          q_reg <= {add_z[0], q_reg[WIDTH-1:1]};
          q_m1  <= q_reg[0];
          count <= count + CW'(1);
          if (last_step) begin
            product <= {add_z[WIDTH:1], add_z[0], q_reg[WIDTH-1:1]};
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// Testbench for booth_mul_seq: models the external add/sub stage and checks against a signed multiply.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [7:0]  add_x;
  logic [7:0]  add_y;
  logic        add_sub;
  logic [8:0]  add_z;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // external 8-bit add/sub stage with 9-bit sign-extended result
  assign add_z = add_sub ? ({add_x[7], add_x} - {add_y[7], add_y})
                         : ({add_x[7], add_x} + {add_y[7], add_y});

  booth_mul_seq #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .add_x        (add_x),
    .add_y        (add_y),
    .add_sub      (add_sub),
    .add_z        (add_z)
  );

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int r;
    r = int'($signed(a)) * int'($signed(b));
    return r[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads one operation and waits for done; returns product, load-to-done latency and busy cycles.
  task automatic run_mul(input logic [7:0] m, input logic [7:0] q,
                         output logic [15:0] p, output int lat, output int busy_cnt,
                         output bit timeout);
    start = 1'b1; multiplicand = m; multiplier = q;
    tick();
    start = 1'b0;
    lat = 0; busy_cnt = 0; timeout = 1'b1; p = '0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) busy_cnt++;
      tick();
      if (done) begin
        lat = i; p = product; timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    tick(); tick();
    n_cmp++;
    if ({busy, done, product, add_x, add_y, add_sub} !== 34'd0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b product=%h add_x=%h add_y=%h add_sub=%b, want all 0",
               busy, done, product, add_x, add_y, add_sub);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    logic [15:0] p; int lat, bc; bit to;
    run_mul(8'd7, 8'd3, p, lat, bc, to);
    n_cmp++;
    if (to || p !== 16'h0015) begin
      n_err++; $display("FAIL basic_7x3: product=%h timeout=%b, want 0015", p, to);
    end
    n_cmp++;
    if (lat !== 8) begin
      n_err++; $display("FAIL basic_latency: got %0d, want 8", lat);
    end
    n_cmp++;
    if (bc !== 8 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_busy: busy cycles=%0d busy_at_done=%b, want 8 and 0", bc, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || product !== 16'h0015) begin
      n_err++; $display("FAIL done_pulse: done=%b product=%h, want 0 0015", done, product);
    end
  endtask

  task automatic test_corners();
    logic [7:0]  ms [4] = '{8'h80, 8'h80, 8'h7F, 8'hFF};
    logic [7:0]  qs [4] = '{8'h80, 8'h7F, 8'h7F, 8'hFF};
    logic [15:0] ex [4] = '{16'h4000, 16'hC080, 16'h3F01, 16'h0001};
    logic [15:0] p; int lat, bc; bit to;
    for (int i = 0; i < 4; i++) begin
      run_mul(ms[i], qs[i], p, lat, bc, to);
      n_cmp++;
      if (to || p !== ex[i]) begin
        n_err++;
        $display("FAIL corner_%0d: %h*%h product=%h timeout=%b, want %h", i, ms[i], qs[i], p, to, ex[i]);
      end
    end
  endtask

  // Checks the add/sub controls every RUN step against the Booth pair {Q[i],Q[i-1]}.
  task automatic test_booth_signals(input logic [7:0] m, input logic [7:0] q);
    logic [7:0] qv; logic prev, exp_sub; logic [7:0] exp_y; int bad;
    qv = q; bad = 0;
    start = 1'b1; multiplicand = m; multiplier = q;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      prev    = (i == 0) ? 1'b0 : qv[i-1];
      exp_sub = qv[i] & ~prev;
      exp_y   = (qv[i] != prev) ? m : 8'h00;
      if (add_sub !== exp_sub || add_y !== exp_y) begin
        bad++;
        $display("FAIL booth_step_%0d: m=%h q=%h add_sub=%b add_y=%h, want %b %h",
                 i, m, q, add_sub, add_y, exp_sub, exp_y);
      end
      tick();
    end
    n_cmp++;
    if (bad != 0) n_err++;
    n_cmp++;
    if (done !== 1'b1 || product !== ref_mul(m, q)) begin
      n_err++;
      $display("FAIL booth_product: m=%h q=%h done=%b product=%h, want 1 %h", m, q, done, product, ref_mul(m, q));
    end
  endtask

  task automatic test_ignore_start();
    bit got;
    start = 1'b1; multiplicand = 8'd5; multiplier = 8'd6;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got = 1'b1; break; end
      tick();
    end
    n_cmp++;
    if (!got || product !== 16'h001E) begin
      n_err++; $display("FAIL ignore_start: product=%h done_seen=%b, want 001E", product, got);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [15:0] p; int lat, bc; bit to;
    start = 1'b1; multiplicand = 8'd100; multiplier = 8'd100;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      n_err++; $display("FAIL reset_abort: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
    end
    rst_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || add_y !== 8'h00) begin
      n_err++; $display("FAIL abort_idle: busy=%b done=%b add_y=%h, want 0 0 00", busy, done, add_y);
    end
    run_mul(8'd2, 8'hFD, p, lat, bc, to);
    n_cmp++;
    if (to || p !== 16'hFFFA) begin
      n_err++; $display("FAIL after_abort: product=%h timeout=%b, want FFFA", p, to);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, q1, m2, q2; logic [15:0] p1, p2; int gap; bit ok1, ok2;
    m1 = 8'($urandom); q1 = 8'($urandom); m2 = 8'($urandom); q2 = 8'($urandom);
    tick();
    start = 1'b1; multiplicand = m1; multiplier = q1;
    tick();
    multiplicand = 8'h00; multiplier = 8'h00;
    ok1 = 1'b0; p1 = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) begin ok1 = 1'b1; p1 = product; break; end
    end
    multiplicand = m2; multiplier = q2;
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_reload: done=%b busy=%b, want 0 1", done, busy);
    end
    start = 1'b0;
    ok2 = 1'b0; gap = 1; p2 = '0;
    for (int i = 0; i < 20; i++) begin
      tick(); gap++;
      if (done) begin ok2 = 1'b1; p2 = product; break; end
    end
    n_cmp++;
    if (!ok1 || p1 !== ref_mul(m1, q1)) begin
      n_err++; $display("FAIL b2b_first: product=%h seen=%b, want %h", p1, ok1, ref_mul(m1, q1));
    end
    n_cmp++;
    if (!ok2 || p2 !== ref_mul(m2, q2) || gap != 9) begin
      n_err++; $display("FAIL b2b_second: product=%h gap=%0d, want %h gap 9", p2, gap, ref_mul(m2, q2));
    end
  endtask

  task automatic test_random();
    logic [7:0] m, q; logic [15:0] p; int lat, bc; bit to; int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      m = 8'($urandom); q = 8'($urandom);
      run_mul(m, q, p, lat, bc, to);
      n_cmp++;
      if (to || p !== ref_mul(m, q) || lat != 8) begin
        n_err++; bad++;
        if (bad <= 10)
          $display("FAIL random_%0d: %h*%h product=%h lat=%0d, want %h lat 8", i, m, q, p, lat, ref_mul(m, q));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_booth_signals(8'h00, 8'hB3);
    test_booth_signals(8'h03, 8'h55);
    test_booth_signals(8'h80, 8'hAA);
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential radix-2 Booth multiplier for signed two's-complement operands, 8x8 -> 16-bit product.
- Sits directly upstream and downstream of the team's 8-bit add/sub stage (`adder`: 8-bit x/y, `flag`=subtract, 9-bit sign-extended result).
- Each cycle it drives that stage's operands and subtract flag, then consumes its 9-bit result to form the next partial product.
- The adder is instantiated by the parent and wired through the `add_*` ports. This block holds no arithmetic beyond shifting and muxing.

Parameters:
- WIDTH, 8, operand width; must equal the add/sub stage width (product is 2*WIDTH, result bus is WIDTH+1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request; sampled only in IDLE or DONE.
- multiplicand  input  WIDTH  signed operand M, captured when start is accepted.
- multiplier  input  WIDTH  signed operand Q, captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when product is valid.
- product  output  2*WIDTH  signed result; holds until the next completion or reset.
- add_x  output  WIDTH  to add/sub stage x: accumulator A.
- add_y  output  WIDTH  to add/sub stage y: M when an operation is needed, else 0.
- add_sub  output  1  to add/sub stage flag: 1 = subtract.
- add_z  input  WIDTH+1  from add/sub stage: sign-extended sum/difference, combinational in the same cycle.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; A, Q, Q_-1, M, count, product = 0; busy=0; done=0. Reset mid-RUN aborts the operation. The product is not updated by the aborted operation.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at edge E0:
  - A<=0, Q<=multiplier, Q_-1<=0, M<=multiplicand, count<=0, state<=RUN.
  - done<=0; product is unchanged.
- DONE with start=0: state<=IDLE and done<=0 at the next edge.
- start in RUN is ignored; operands are not resampled.
- RUN, combinational per cycle, with bits={Q[0],Q_-1}:
  - 01: add_y=M, add_sub=0.
  - 10: add_y=M, add_sub=1.
  - 00/11: add_y=0, add_sub=0.
  - add_x=A in all cases.
  - In IDLE/DONE the `add_*` outputs drive 0.
- RUN step at each edge, an arithmetic right shift of the 9-bit result:
  - A<=add_z[WIDTH:1].
  - Q<={add_z[0], Q[WIDTH-1:1]}.
  - Q_-1<=Q[0].
  - count<=count+1.
  - Using the full 9-bit add_z makes M=-128 exact; there is no overflow case.
- Completion: the step at which count==WIDTH-1 is the final step.
  - At that edge: product<={add_z[WIDTH:1], add_z[0], Q[WIDTH-1:1]}, done<=1, state<=DONE.
- Latency: load at E0, steps at E1..E8, done high during the cycle after E8 (8 cycles after the load edge).
- busy=1 exactly for the cycles in RUN (after E0 through E8).
- Back-to-back: start=1 while done=1 reloads at that edge. done drops the following cycle, and busy rises.
- Result is product = multiplicand*multiplier as a signed 2*WIDTH value for all input pairs.

Test Plan:
- M=7, Q=3, start pulse -> done 8 cycles after load edge, product=0x0015, busy high exactly 8 cycles.
- M=-128, Q=-128 -> product=0x4000. M=-128, Q=127 -> product=0xC080. M=127, Q=127 -> product=0x3F01.
- M=-1, Q=-1 -> 0x0001. M=0, Q=-77 -> 0x0000, with add_sub=0 and add_y=0 every RUN cycle. Q=0x55 -> add_sub alternates as Booth pairs dictate.
- start with M=5, Q=6, then start with M=9, Q=9 at cycle 3 of RUN -> ignored; product=0x001E.
- rst_n=0 at cycle 4 of RUN -> next cycle busy=0, done=0, product=0x0000, state IDLE. A subsequent 2*-3 run -> 0xFFFA.
- Back-to-back: start held high through done -> second operation loads on the done cycle. Two consecutive done pulses 9 cycles apart carry correct products. Random 1000-pair signed sweep is checked against a reference multiply.
